// File: rtl/onehot_pkg.sv
// Shared types for the one-hot encoder stream: default widths, code/index types,
// the encoded word carried through the output and skid registers, and a decoder model.
package onehot_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = $clog2(IN_W);

  typedef logic [IN_W-1:0]  onehot_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    idx_t idx;
    logic err;
  } enc_word_t;

  // Matches the 3-to-8 decoder this block inverts: index k -> bit k set.
  function automatic onehot_t idx_to_onehot(input idx_t i);
    onehot_t w_one;
    w_one = onehot_t'(1);
    return w_one << i;
  endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational LSB-first priority encoder; the non-one-hot flag is only built
// when ONEHOT_CHECK_EN is defined, otherwise o_err is tied low.
module onehot_prio_enc #(
  parameter int IN_W  = onehot_pkg::IN_W,
  localparam int IDX_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  i_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_err
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (i_onehot[i]) o_idx = IDX_W'(i);
    end
  end

`ifdef ONEHOT_CHECK_EN
  assign o_err = ($countones(i_onehot) != 1);
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: rtl/onehot_encoder_stream.sv
// Registered one-hot to binary encoder on a valid/ready stream with a 2-entry skid
// buffer and an accepted-word counter. Define ONEHOT_CHECK_EN to flag non-one-hot inputs.
module onehot_encoder_stream #(
  parameter int IN_W  = onehot_pkg::IN_W,
  parameter int CNT_W = 8,
  localparam int IDX_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
  } word_t;

  // Handshake: a word moves on a posedge where valid && ready; a producer holds
  // valid and data steady until that edge. in_ready depends only on r_skid_full.
  word_t            r_out;
  word_t            r_skid;
  logic             r_out_valid;
  logic             r_skid_full;
  logic [CNT_W-1:0] r_cnt;

  word_t            w_enc;
  logic             w_in_fire;
  logic             w_out_free;

  onehot_prio_enc #(.IN_W(IN_W)) u_enc (
    .i_onehot (in_onehot),
    .o_idx    (w_enc.idx),
    .o_err    (w_enc.err)
  );

  assign in_ready   = !r_skid_full;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // The skid only fills while the out reg is stalled, so in_ready is never high
  // with a full skid and an incoming word never competes with a skid refill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        r_out       <= r_skid;
        r_out_valid <= 1'b1;
        r_skid_full <= 1'b0;
      end else if (w_in_fire) begin
        r_out       <= w_enc;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid      <= w_enc;
      r_skid_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out.idx;
  assign out_err   = r_out.err;
  assign cnt       = r_cnt;

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Directed bench for onehot_encoder_stream: sweep, backpressure, error flag, counter
// wrap, mid-stream reset, then a long random valid/ready run against a queue.
module tb_onehot_encoder_stream;
  import onehot_pkg::*;

  localparam int CNT_W  = 8;
  localparam int N_RND  = 10000;
  localparam int RND_TO = 60000;
`ifdef ONEHOT_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  onehot_t          in_onehot = '0;
  logic             in_ready;
  logic             out_valid;
  idx_t             out_idx;
  logic             out_err;
  logic [CNT_W-1:0] cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  idx_t exp_q[$];

  always #5 clk = ~clk;

  onehot_encoder_stream #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .cnt       (cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   acc;
    int   got;
    int   cyc;
    logic in_fire;
    logic out_fire;
    logic stall;
    idx_t held_idx;
    idx_t cur_idx;
    idx_t exp_idx;

    // Reset state
    tick();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_idx",   32'(out_idx),   32'(0));
    check("rst_out_err",   32'(out_err),   32'(0));
    check("rst_cnt",       32'(cnt),       32'(0));
    reset = 1'b0;
    tick();
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_idle",      32'(out_valid), 32'(0));

    // Sweep every one-hot code at full rate
    out_ready = 1'b1;
    for (int k = 0; k < IN_W; k++) begin
      in_valid  = 1'b1;
      in_onehot = idx_to_onehot(idx_t'(k));
      tick();
      check("sweep_valid", 32'(out_valid), 32'(1));
      check("sweep_idx",   32'(out_idx),   32'(k));
      check("sweep_err",   32'(out_err),   32'(0));
      check("sweep_ready", 32'(in_ready),  32'(1));
    end
    in_valid = 1'b0;
    check("sweep_cnt", 32'(cnt), 32'(8));
    tick();
    check("sweep_drained", 32'(out_valid), 32'(0));

    // Backpressure: second word parks in the skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 8'h04;
    tick();
    check("bp_first_valid", 32'(out_valid), 32'(1));
    check("bp_first_idx",   32'(out_idx),   32'(2));
    check("bp_first_ready", 32'(in_ready),  32'(1));
    in_onehot = 8'h10;
    tick();
    check("bp_full_ready", 32'(in_ready), 32'(0));
    check("bp_full_idx",   32'(out_idx),  32'(2));
    in_valid = 1'b0;
    tick();
    check("bp_hold_valid", 32'(out_valid), 32'(1));
    check("bp_hold_idx",   32'(out_idx),   32'(2));
    check("bp_hold_ready", 32'(in_ready),  32'(0));
    out_ready = 1'b1;
    tick();
    check("bp_skid_valid", 32'(out_valid), 32'(1));
    check("bp_skid_idx",   32'(out_idx),   32'(4));
    check("bp_skid_ready", 32'(in_ready),  32'(1));
    tick();
    check("bp_empty", 32'(out_valid), 32'(0));
    check("bp_cnt",   32'(cnt),       32'(10));

    // Zero and multi-hot inputs
    in_valid  = 1'b1;
    in_onehot = 8'h00;
    tick();
    check("zero_idx", 32'(out_idx), 32'(0));
    check("zero_err", 32'(out_err), 32'(ERR_EN));
    in_onehot = 8'h06;
    tick();
    check("multi_idx", 32'(out_idx), 32'(1));
    check("multi_err", 32'(out_err), 32'(ERR_EN));
    in_valid  = 1'b0;
    in_onehot = 8'h01;
    tick();
    check("err_cnt", 32'(cnt), 32'(12));

    // Counter wrap from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrap_start", 32'(cnt), 32'(0));
    for (int n = 1; n <= 257; n++) begin
      in_valid  = 1'b1;
      in_onehot = idx_to_onehot(idx_t'(n % IN_W));
      tick();
      if (n == 255) check("wrap_255", 32'(cnt), 32'(255));
      if (n == 256) check("wrap_256", 32'(cnt), 32'(0));
    end
    check("wrap_257", 32'(cnt), 32'(1));
    check("wrap_idx", 32'(out_idx), 32'(257 % IN_W));

    // Reset with out reg and skid both full
    out_ready = 1'b0;
    in_onehot = 8'h20;
    tick();
    in_valid = 1'b0;
    check("mrst_full_ready", 32'(in_ready),  32'(0));
    check("mrst_full_valid", 32'(out_valid), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("mrst_async_valid", 32'(out_valid), 32'(0));
    check("mrst_async_cnt",   32'(cnt),       32'(0));
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("mrst_ready",    32'(in_ready),  32'(1));
    check("mrst_no_stale", 32'(out_valid), 32'(0));
    tick();
    check("mrst_no_stale2", 32'(out_valid), 32'(0));

    // Random valid/ready through the decoder model
    acc = 0;
    got = 0;
    cyc = 0;
    cur_idx = '0;
    while (got < N_RND && cyc < RND_TO) begin
      if (!in_valid && acc < N_RND && $urandom_range(0, 3) != 0) begin
        in_valid  = 1'b1;
        cur_idx   = idx_t'($urandom_range(0, IN_W - 1));
        in_onehot = idx_to_onehot(cur_idx);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      stall     = out_valid && !out_ready;
      held_idx  = out_idx;
      if (out_fire) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL rnd_spurious observed=%0h expected=none", out_idx);
        end
        if (exp_q.size() != 0) begin
          exp_idx = exp_q.pop_front();
          check("rnd_data", 32'(out_idx), 32'(exp_idx));
          check("rnd_err",  32'(out_err), 32'(0));
          got++;
        end
      end
      if (in_fire) begin
        exp_q.push_back(cur_idx);
        acc++;
      end
      tick();
      cyc++;
      if (stall) begin
        check("rnd_hold_valid", 32'(out_valid), 32'(1));
        check("rnd_hold_idx",   32'(out_idx),   32'(held_idx));
      end
      if (in_fire) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rnd_words_out", 32'(got),          32'(N_RND));
    check("rnd_leftover",  32'(exp_q.size()), 32'(0));
    check("rnd_cnt",       32'(cnt),          32'(acc % 256));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
